// File: rtl/dma_desc_tag_tracker.sv
// Per-client DMA descriptor front end: assigns ring-slot hardware tags,
// collects out-of-order status returns and retires completions in issue order.
module dma_desc_tag_tracker #(
    parameter int DMA_ADDR_WIDTH = 64,
    parameter int RAM_SEL_WIDTH  = 2,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 16,
    parameter int TAG_WIDTH      = 5,
    parameter int USER_TAG_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [DMA_ADDR_WIDTH-1:0] s_axis_req_dma_addr,
    input  logic [RAM_SEL_WIDTH-1:0]  s_axis_req_ram_sel,
    input  logic [RAM_ADDR_WIDTH-1:0] s_axis_req_ram_addr,
    input  logic [LEN_WIDTH-1:0]      s_axis_req_len,
    input  logic [USER_TAG_WIDTH-1:0] s_axis_req_tag,
    input  logic                      s_axis_req_valid,
    output logic                      s_axis_req_ready,

    output logic [DMA_ADDR_WIDTH-1:0] m_axis_desc_dma_addr,
    output logic [RAM_SEL_WIDTH-1:0]  m_axis_desc_ram_sel,
    output logic [RAM_ADDR_WIDTH-1:0] m_axis_desc_ram_addr,
    output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
    output logic [TAG_WIDTH-1:0]      m_axis_desc_tag,
    output logic                      m_axis_desc_valid,
    input  logic                      m_axis_desc_ready,

    input  logic [TAG_WIDTH-1:0]      s_axis_desc_status_tag,
    input  logic [3:0]                s_axis_desc_status_error,
    input  logic                      s_axis_desc_status_valid,

    output logic [USER_TAG_WIDTH-1:0] m_axis_cpl_tag,
    output logic [3:0]                m_axis_cpl_error,
    output logic                      m_axis_cpl_valid,
    input  logic                      m_axis_cpl_ready,

    output logic [TAG_WIDTH:0]        occupancy,
    output logic                      stat_stray_status
);

    localparam int DEPTH = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] FULL_OCC = {1'b1, {TAG_WIDTH{1'b0}}};

    logic [TAG_WIDTH:0]        wr_ptr_q, wr_ptr_d;
    logic [TAG_WIDTH:0]        rd_ptr_q, rd_ptr_d;
    logic [TAG_WIDTH:0]        occ_q, occ_d;
    logic [DEPTH-1:0]          done_q, done_d;
    logic                      desc_valid_q, desc_valid_d;
    logic                      cpl_valid_q, cpl_valid_d;
    logic                      stray_q, stray_d;

    logic [USER_TAG_WIDTH-1:0] tag_ram [DEPTH];
    logic [3:0]                err_ram [DEPTH];

    logic [DMA_ADDR_WIDTH-1:0] desc_addr_q;
    logic [RAM_SEL_WIDTH-1:0]  desc_sel_q;
    logic [RAM_ADDR_WIDTH-1:0] desc_raddr_q;
    logic [LEN_WIDTH-1:0]      desc_len_q;
    logic [TAG_WIDTH-1:0]      desc_tag_q;
    logic [USER_TAG_WIDTH-1:0] cpl_tag_q;
    logic [3:0]                cpl_err_q;

    logic [TAG_WIDTH-1:0]      wr_slot, rd_slot, st_off;
    logic                      full, accept, in_win, st_ok, retire;

    // Window test is relative to the head, so the slot being issued this
    // cycle is outside it and a status for it is reported as stray.
    always_comb begin
        wr_slot          = wr_ptr_q[TAG_WIDTH-1:0];
        rd_slot          = rd_ptr_q[TAG_WIDTH-1:0];
        full             = (occ_q == FULL_OCC);
        s_axis_req_ready = !full && (!desc_valid_q || m_axis_desc_ready);
        accept           = s_axis_req_valid && s_axis_req_ready;
        st_off           = s_axis_desc_status_tag - rd_slot;
        in_win           = ({1'b0, st_off} < occ_q);
        st_ok            = s_axis_desc_status_valid && in_win
                           && !done_q[s_axis_desc_status_tag];
        retire           = (occ_q != '0) && done_q[rd_slot]
                           && (!cpl_valid_q || m_axis_cpl_ready);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + {{TAG_WIDTH{1'b0}}, accept};
        rd_ptr_d     = rd_ptr_q + {{TAG_WIDTH{1'b0}}, retire};
        occ_d        = wr_ptr_d - rd_ptr_d;
        done_d       = done_q;
        desc_valid_d = desc_valid_q;
        cpl_valid_d  = cpl_valid_q;
        stray_d      = s_axis_desc_status_valid && !st_ok;
        if (retire) done_d[rd_slot] = 1'b0;
        if (accept) done_d[wr_slot] = 1'b0;
        if (st_ok) done_d[s_axis_desc_status_tag] = 1'b1;
        if (accept) begin
            desc_valid_d = 1'b1;
        end else if (m_axis_desc_ready) begin
            desc_valid_d = 1'b0;
        end
        if (retire) begin
            cpl_valid_d = 1'b1;
        end else if (m_axis_cpl_ready) begin
            cpl_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            done_q       <= '0;
            desc_valid_q <= 1'b0;
            cpl_valid_q  <= 1'b0;
            stray_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            done_q       <= done_d;
            desc_valid_q <= desc_valid_d;
            cpl_valid_q  <= cpl_valid_d;
            stray_q      <= stray_d;
        end
    end

    // Payload storage carries no reset; valids qualify it.
    always_ff @(posedge clk) begin
        if (accept) begin
            desc_addr_q      <= s_axis_req_dma_addr;
            desc_sel_q       <= s_axis_req_ram_sel;
            desc_raddr_q     <= s_axis_req_ram_addr;
            desc_len_q       <= s_axis_req_len;
            desc_tag_q       <= wr_slot;
            tag_ram[wr_slot] <= s_axis_req_tag;
        end
        if (st_ok) begin
            err_ram[s_axis_desc_status_tag] <= s_axis_desc_status_error;
        end
        if (retire) begin
            cpl_tag_q <= tag_ram[rd_slot];
            cpl_err_q <= err_ram[rd_slot];
        end
    end

    assign m_axis_desc_dma_addr = desc_addr_q;
    assign m_axis_desc_ram_sel  = desc_sel_q;
    assign m_axis_desc_ram_addr = desc_raddr_q;
    assign m_axis_desc_len      = desc_len_q;
    assign m_axis_desc_tag      = desc_tag_q;
    assign m_axis_desc_valid    = desc_valid_q;
    assign m_axis_cpl_tag       = cpl_tag_q;
    assign m_axis_cpl_error     = cpl_err_q;
    assign m_axis_cpl_valid     = cpl_valid_q;
    assign occupancy            = occ_q;
    assign stat_stray_status    = stray_q;

endmodule

// File: tb/tb_dma_desc_tag_tracker.sv
// Directed scoreboard bench for dma_desc_tag_tracker: descriptors and
// completions are queued at issue time and checked at their handshakes.
module tb_dma_desc_tag_tracker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_axis_req_dma_addr = '0;
    logic [1:0]  s_axis_req_ram_sel = '0;
    logic [15:0] s_axis_req_ram_addr = '0;
    logic [15:0] s_axis_req_len = '0;
    logic [7:0]  s_axis_req_tag = '0;
    logic        s_axis_req_valid = 1'b0;
    logic        s_axis_req_ready;
    logic [63:0] m_axis_desc_dma_addr;
    logic [1:0]  m_axis_desc_ram_sel;
    logic [15:0] m_axis_desc_ram_addr;
    logic [15:0] m_axis_desc_len;
    logic [4:0]  m_axis_desc_tag;
    logic        m_axis_desc_valid;
    logic        m_axis_desc_ready = 1'b1;
    logic [4:0]  s_axis_desc_status_tag = '0;
    logic [3:0]  s_axis_desc_status_error = '0;
    logic        s_axis_desc_status_valid = 1'b0;
    logic [7:0]  m_axis_cpl_tag;
    logic [3:0]  m_axis_cpl_error;
    logic        m_axis_cpl_valid;
    logic        m_axis_cpl_ready = 1'b1;
    logic [5:0]  occupancy;
    logic        stat_stray_status;

    dma_desc_tag_tracker dut (
        .clk                      (clk),
        .rst                      (rst),
        .s_axis_req_dma_addr      (s_axis_req_dma_addr),
        .s_axis_req_ram_sel       (s_axis_req_ram_sel),
        .s_axis_req_ram_addr      (s_axis_req_ram_addr),
        .s_axis_req_len           (s_axis_req_len),
        .s_axis_req_tag           (s_axis_req_tag),
        .s_axis_req_valid         (s_axis_req_valid),
        .s_axis_req_ready         (s_axis_req_ready),
        .m_axis_desc_dma_addr     (m_axis_desc_dma_addr),
        .m_axis_desc_ram_sel      (m_axis_desc_ram_sel),
        .m_axis_desc_ram_addr     (m_axis_desc_ram_addr),
        .m_axis_desc_len          (m_axis_desc_len),
        .m_axis_desc_tag          (m_axis_desc_tag),
        .m_axis_desc_valid        (m_axis_desc_valid),
        .m_axis_desc_ready        (m_axis_desc_ready),
        .s_axis_desc_status_tag   (s_axis_desc_status_tag),
        .s_axis_desc_status_error (s_axis_desc_status_error),
        .s_axis_desc_status_valid (s_axis_desc_status_valid),
        .m_axis_cpl_tag           (m_axis_cpl_tag),
        .m_axis_cpl_error         (m_axis_cpl_error),
        .m_axis_cpl_valid         (m_axis_cpl_valid),
        .m_axis_cpl_ready         (m_axis_cpl_ready),
        .occupancy                (occupancy),
        .stat_stray_status        (stat_stray_status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  tag;
        logic [15:0] len;
        logic [63:0] addr;
        logic [1:0]  sel;
        logic [15:0] raddr;
    } desc_t;

    desc_t      dq[$];
    logic [4:0] cq[$];
    logic [7:0] model_user [32];
    logic [3:0] model_err [32];
    logic [5:0] model_wr = '0;

    int vectors = 0;
    int miscompares = 0;
    int cpl_seen = 0;
    int desc_seen = 0;
    int stray_cnt = 0;
    int c0, s0, d0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            dq.delete();
            cq.delete();
        end else begin
            if (stat_stray_status) stray_cnt++;
            if (m_axis_desc_valid && m_axis_desc_ready) begin
                desc_t e;
                desc_seen++;
                chk("desc_pending", 64'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    chk("desc_tag", m_axis_desc_tag, e.tag);
                    chk("desc_len", m_axis_desc_len, e.len);
                    chk("desc_addr", m_axis_desc_dma_addr, e.addr);
                    chk("desc_sel", m_axis_desc_ram_sel, e.sel);
                    chk("desc_raddr", m_axis_desc_ram_addr, e.raddr);
                end
            end
            if (m_axis_cpl_valid && m_axis_cpl_ready) begin
                logic [4:0] s;
                cpl_seen++;
                chk("cpl_pending", 64'(cq.size() != 0), 1);
                if (cq.size() != 0) begin
                    s = cq.pop_front();
                    chk("cpl_tag", m_axis_cpl_tag, model_user[s]);
                    chk("cpl_err", m_axis_cpl_error, model_err[s]);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_wr = '0;
    endtask

    task automatic send_req(input logic [7:0] u, input logic [15:0] len);
        desc_t e;
        bit ok;
        logic [4:0] slot;
        ok = 1'b0;
        slot = model_wr[4:0];
        s_axis_req_valid    = 1'b1;
        s_axis_req_tag      = u;
        s_axis_req_len      = len;
        s_axis_req_dma_addr = {56'hD0_0000_0000_0000, u};
        s_axis_req_ram_sel  = u[1:0];
        s_axis_req_ram_addr = {8'h5A, u};
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_axis_req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_accept", 64'(ok), 1);
        if (ok) begin
            e.tag   = slot;
            e.len   = len;
            e.addr  = {56'hD0_0000_0000_0000, u};
            e.sel   = u[1:0];
            e.raddr = {8'h5A, u};
            dq.push_back(e);
            cq.push_back(slot);
            model_user[slot] = u;
            model_err[slot]  = 4'h0;
            model_wr++;
        end
        @(posedge clk);
        #1;
        s_axis_req_valid = 1'b0;
    endtask

    task automatic send_status(input logic [4:0] t, input logic [3:0] e, input bit upd);
        if (upd) model_err[t] = e;
        s_axis_desc_status_valid = 1'b1;
        s_axis_desc_status_tag   = t;
        s_axis_desc_status_error = e;
        @(posedge clk);
        #1;
        s_axis_desc_status_valid = 1'b0;
    endtask

    task automatic wait_cpl(input int n);
        for (int i = 0; i < 200 && cpl_seen < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk("cpl_count", cpl_seen, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        chk("rst_desc_valid", m_axis_desc_valid, 0);
        chk("rst_cpl_valid", m_axis_cpl_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_stray", stat_stray_status, 0);
        rst = 1'b0;
        idle(1);
        chk("idle_req_ready", s_axis_req_ready, 1);

        // single descriptor round trip
        c0 = cpl_seen;
        send_req(8'hA5, 16'h0100);
        chk("t1_desc_valid", m_axis_desc_valid, 1);
        chk("t1_desc_tag", m_axis_desc_tag, 0);
        chk("t1_occ", occupancy, 1);
        send_status(5'd0, 4'h0, 1'b1);
        chk("t1_cpl_early", m_axis_cpl_valid, 0);
        idle(1);
        chk("t1_cpl_valid", m_axis_cpl_valid, 1);
        chk("t1_cpl_tag", m_axis_cpl_tag, 8'hA5);
        idle(2);
        chk("t1_occ_end", occupancy, 0);
        chk("t1_cpl_n", cpl_seen - c0, 1);

        // out-of-order status, in-order completion
        do_reset();
        c0 = cpl_seen;
        for (int i = 1; i <= 4; i++) send_req(8'(i), 16'(16 * i));
        send_status(5'd3, 4'h0, 1'b1);
        send_status(5'd1, 4'h5, 1'b1);
        idle(2);
        chk("t2_hold_cpl", m_axis_cpl_valid, 0);
        chk("t2_hold_n", cpl_seen - c0, 0);
        chk("t2_occ", occupancy, 4);
        send_status(5'd0, 4'h0, 1'b1);
        send_status(5'd2, 4'h0, 1'b1);
        wait_cpl(c0 + 4);
        idle(1);
        chk("t2_occ_end", occupancy, 0);

        // fill all 32 slots, then free one and wrap
        do_reset();
        c0 = cpl_seen;
        for (int i = 0; i < 32; i++) send_req(8'(8'h40 + i), 16'h0200);
        chk("t3_full_ready", s_axis_req_ready, 0);
        chk("t3_full_occ", occupancy, 32);
        send_status(5'd0, 4'h2, 1'b1);
        chk("t3_still_full", s_axis_req_ready, 0);
        idle(1);
        chk("t3_ready_back", s_axis_req_ready, 1);
        chk("t3_occ31", occupancy, 31);
        wait_cpl(c0 + 1);
        send_req(8'hEE, 16'h0333);
        chk("t3_wrap_tag", m_axis_desc_tag, 0);
        chk("t3_occ_refull", occupancy, 32);

        // descriptor and completion backpressure
        do_reset();
        c0 = cpl_seen;
        d0 = desc_seen;
        m_axis_desc_ready = 1'b0;
        send_req(8'h61, 16'h0610);
        s_axis_req_valid    = 1'b1;
        s_axis_req_tag      = 8'h62;
        s_axis_req_len      = 16'h0620;
        s_axis_req_dma_addr = {56'hD0_0000_0000_0000, 8'h62};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_desc_hold_v", m_axis_desc_valid, 1);
            chk("t4_desc_hold_tag", m_axis_desc_tag, 0);
            chk("t4_desc_hold_len", m_axis_desc_len, 16'h0610);
            chk("t4_req_blocked", s_axis_req_ready, 0);
        end
        @(posedge clk);
        #1;
        m_axis_desc_ready = 1'b1;
        send_req(8'h62, 16'h0620);
        idle(2);
        chk("t4_desc_n", desc_seen - d0, 2);
        m_axis_cpl_ready = 1'b0;
        send_status(5'd0, 4'h1, 1'b1);
        send_status(5'd1, 4'h3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_cpl_hold_v", m_axis_cpl_valid, 1);
            chk("t4_cpl_hold_tag", m_axis_cpl_tag, 8'h61);
            chk("t4_retire_stall", occupancy, 1);
        end
        @(posedge clk);
        #1;
        m_axis_cpl_ready = 1'b1;
        wait_cpl(c0 + 2);

        // stray and duplicate status
        do_reset();
        c0 = cpl_seen;
        s0 = stray_cnt;
        for (int i = 0; i < 3; i++) send_req(8'(8'h70 + i), 16'h0040);
        send_status(5'd7, 4'hF, 1'b0);
        send_status(5'd1, 4'h3, 1'b1);
        send_status(5'd1, 4'h9, 1'b0);
        idle(2);
        chk("t5_stray_n", stray_cnt - s0, 2);
        chk("t5_no_cpl", cpl_seen - c0, 0);
        send_status(5'd0, 4'h0, 1'b1);
        send_status(5'd2, 4'h0, 1'b1);
        wait_cpl(c0 + 3);
        idle(3);
        chk("t5_cpl_once", cpl_seen - c0, 3);
        chk("t5_stray_end", stray_cnt - s0, 2);

        // asynchronous reset with work outstanding
        do_reset();
        m_axis_cpl_ready = 1'b0;
        send_req(8'h91, 16'h0010);
        send_req(8'h92, 16'h0020);
        send_status(5'd0, 4'h0, 1'b1);
        m_axis_desc_ready = 1'b0;
        send_req(8'h93, 16'h0030);
        chk("t6_pre_desc_v", m_axis_desc_valid, 1);
        chk("t6_pre_cpl_v", m_axis_cpl_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_desc_v", m_axis_desc_valid, 0);
        chk("t6_cpl_v", m_axis_cpl_valid, 0);
        chk("t6_occ", occupancy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_wr = '0;
        m_axis_desc_ready = 1'b1;
        m_axis_cpl_ready = 1'b1;
        c0 = cpl_seen;
        s0 = stray_cnt;
        send_status(5'd1, 4'h0, 1'b0);
        idle(3);
        chk("t6_post_stray", stray_cnt - s0, 1);
        chk("t6_post_cpl", cpl_seen - c0, 0);
        chk("t6_post_occ", occupancy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_desc_tag_tracker.md
Name: dma_desc_tag_tracker

Overview:
- Per-client front end that sits directly upstream of one input port of the DMA descriptor mux.
- Accepts client descriptors carrying an opaque user tag and assigns each one a sequential hardware tag from a ring of 2**TAG_WIDTH slots.
- Issues the descriptor to the mux port and collects the out-of-order status returns for that port.
- Delivers completions to the client in issue order, each with its original user tag and error code.

Parameters:
- DMA_ADDR_WIDTH, 64, DMA address width.
- RAM_SEL_WIDTH, 2, RAM segment select width.
- RAM_ADDR_WIDTH, 16, RAM address width.
- LEN_WIDTH, 16, transfer length width.
- TAG_WIDTH, 5, hardware tag width. Ring depth DEPTH = 2**TAG_WIDTH. Must equal the mux input tag width.
- USER_TAG_WIDTH, 8, client tag width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axis_req_dma_addr / _ram_sel / _ram_addr / _len  in  widths per parameters  client descriptor fields
- s_axis_req_tag  in  USER_TAG_WIDTH  client tag
- s_axis_req_valid  in  1;  s_axis_req_ready  out  1
- m_axis_desc_dma_addr / _ram_sel / _ram_addr / _len  out  widths per parameters  descriptor to mux port
- m_axis_desc_tag  out  TAG_WIDTH  hardware tag
- m_axis_desc_valid  out  1;  m_axis_desc_ready  in  1
- s_axis_desc_status_tag  in  TAG_WIDTH;  s_axis_desc_status_error  in  4;  s_axis_desc_status_valid  in  1  status from mux port (no backpressure)
- m_axis_cpl_tag  out  USER_TAG_WIDTH;  m_axis_cpl_error  out  4;  m_axis_cpl_valid  out  1;  m_axis_cpl_ready  in  1  in-order completion
- occupancy  out  TAG_WIDTH+1  number of outstanding slots
- stat_stray_status  out  1  single-cycle pulse on an unexpected status

Behaviour:
- Reset (async assert, sync-released logic):
  - wr_ptr = rd_ptr = 0; done bitmap = 0.
  - All valids 0, occupancy 0, stat_stray_status 0.
  - Data registers are not reset.
- Pointers are TAG_WIDTH+1 bits. Slot index = ptr[TAG_WIDTH-1:0]. occupancy = wr_ptr - rd_ptr, modulo 2**(TAG_WIDTH+1).
- Full when occupancy == DEPTH; empty when occupancy == 0.
- Issue path:
  - s_axis_req_ready = !full && (!m_axis_desc_valid || m_axis_desc_ready).
  - On accept:
    - Descriptor fields are registered onto m_axis_desc_*, with m_axis_desc_tag = wr_ptr[TAG_WIDTH-1:0].
    - m_axis_desc_valid is set the next cycle (latency 1).
    - User tag is written to tag_ram[slot]; done[slot] is cleared; wr_ptr increments.
  - m_axis_desc_* stays stable while valid && !ready.
  - Back-to-back accepts sustain 1 descriptor/cycle while ready is high.
- Status path:
  - A status_valid whose slot lies in [rd_ptr, wr_ptr) and has done == 0 sets done[slot] and stores the error in err_ram[slot].
  - A status for a slot outside that window, or for one already done, is dropped and pulses stat_stray_status for one cycle (registered, 1-cycle latency).
  - A status for the slot being issued in the same cycle counts as stray.
- Retire path:
  - When done[rd_ptr slot] == 1 and (!m_axis_cpl_valid || m_axis_cpl_ready):
    - m_axis_cpl_tag and m_axis_cpl_error are loaded from the RAMs and m_axis_cpl_valid is set the next cycle.
    - done[slot] is cleared and rd_ptr increments.
  - Completions are strictly in issue order; a later done slot waits behind an undone head.
  - Retire rate is at most 1/cycle.
- Simultaneous events:
  - Accept and retire in the same cycle: occupancy unchanged.
  - A status setting the head slot in cycle N can retire no earlier than cycle N+1, so completion valid appears at N+2.
  - Status and retire on different slots in the same cycle both take effect.
- Full boundary:
  - At occupancy == DEPTH, req_ready = 0.
  - A retire in cycle N raises req_ready in cycle N+1.
  - Pointer wrap at DEPTH and 2*DEPTH is seamless.
- Reset mid-operation: all outstanding slots are discarded without completions. Later status returns for pre-reset tags hit an empty window and are reported as stray.
- occupancy is registered and reflects pointer state after each clock edge.

Test Plan:
- Single descriptor, user tag 0xA5, len 0x100 -> desc valid 1 cycle after accept, desc_tag 0. Status tag 0, error 0 -> cpl valid 2 cycles later with tag 0xA5, error 0. occupancy returns 0.
- Issue 4 descriptors (user tags 1,2,3,4). Return status in order 3,1,0,2 with error 5 on tag 1 -> completions emitted in order 1,2,3,4 with errors 0,5,0,0. First completion appears only after the tag-0 status.
- TAG_WIDTH=5: issue 32 descriptors with no status -> req_ready 0 and occupancy 32. Status tag 0 -> one completion, then req_ready 1. The 33rd descriptor receives desc_tag 0.
- Hold m_axis_desc_ready 0 for 3 cycles with a pending request -> desc fields stable, req_ready 0, no descriptor lost. Repeat with cpl_ready 0 -> completion held stable and retires stall.
- Status for tag 7 with only tags 0..2 outstanding, then a duplicate status on tag 1 -> stat_stray_status pulses twice. Bitmap is unchanged by the stray; tag 1 completes exactly once.
- Assert rst asynchronously with 3 outstanding -> all valids drop immediately and occupancy 0. A post-reset status on tag 1 -> stray pulse, no completion.
